cache_lookup_ctrl: RTL

Direct-mapped read-cache controller that drives the valid-bit RAM's port (index, read strobe, write strobe), consuming its registered valid output. It accepts one CPU read at a time, checks the valid bit and an internal tag array, and returns data on a hit. On a miss it fetches the line over a request/acknowledge memory handshake, writes the data and tag arrays, and sets the valid bit. It sits between the CPU load path and main memory, alongside the valid-bit RAM.

---
 rtl/cache_lookup_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cache_lookup_ctrl.sv
// rtl/cache_lookup_ctrl.sv - direct-mapped read-cache controller with valid-bit RAM port and refill handshake
module cache_lookup_ctrl #(
  parameter int INDEX     = 3,
  parameter int CACHESIZE = 8,
  parameter int MEM_BITS  = 5,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic [MEM_BITS-1:0] cpu_addr,
  output logic                cpu_ready,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_hit,
  output logic [INDEX-1:0]    vr_address,
  output logic                vr_read,
  output logic                vr_write,
  input  logic                vr_valid,
  output logic                mem_req,
  output logic [MEM_BITS-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);

  localparam int TAG_W = MEM_BITS - INDEX;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    COMPARE = 3'd2,
    MISS    = 3'd3,
    FILL    = 3'd4,
    RESPOND = 3'd5
  } state_t;

  state_t              state;
  logic [MEM_BITS-1:0] req_addr;
  logic [TAG_W-1:0]    tag_q;

  // Line storage; validity lives only in the external valid-bit RAM, so no reset here
  logic [DATA_W-1:0]   data_mem [CACHESIZE];
  logic [TAG_W-1:0]    tag_mem  [CACHESIZE];

  logic [INDEX-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit_now;
  logic                fill_now;

  assign req_idx  = req_addr[INDEX-1:0];
  assign req_tag  = req_addr[MEM_BITS-1:INDEX];
  assign hit_now  = vr_valid && (tag_q == req_tag);
  // A refill is committed only on an acknowledged MISS cycle that is not being reset
  assign fill_now = !reset && (state == MISS) && mem_ack;

  // Refill write of the data and tag arrays when the memory acknowledges
  always_ff @(posedge clk) begin
    if (fill_now) begin
      data_mem[req_idx] <= mem_rdata;
      tag_mem[req_idx]  <= req_tag;
    end
  end

  // Controller FSM; every output is registered and set on entry to the state that owns it
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_addr   <= '0;
      tag_q      <= '0;
      cpu_ready  <= 1'b1;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      cpu_hit    <= 1'b0;
      vr_address <= '0;
      vr_read    <= 1'b0;
      vr_write   <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_addr   <= cpu_addr;
            cpu_ready  <= 1'b0;
            vr_read    <= 1'b1;
            vr_address <= cpu_addr[INDEX-1:0];
            state      <= LOOKUP;
          end
        end
        LOOKUP: begin
          // vr_valid for this index arrives registered during COMPARE
          tag_q   <= tag_mem[req_idx];
          vr_read <= 1'b0;
          state   <= COMPARE;
        end
        COMPARE: begin
          if (hit_now) begin
            cpu_rdata  <= data_mem[req_idx];
            cpu_rvalid <= 1'b1;
            cpu_hit    <= 1'b1;
            if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
            state      <= RESPOND;
          end else begin
            mem_req    <= 1'b1;
            mem_addr   <= req_addr;
            if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
            state      <= MISS;
          end
        end
        MISS: begin
          if (mem_ack) begin
            cpu_rdata <= mem_rdata;
            mem_req   <= 1'b0;
            vr_write  <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          vr_write   <= 1'b0;
          cpu_rvalid <= 1'b1;
          cpu_hit    <= 1'b0;
          state      <= RESPOND;
        end
        RESPOND: begin
          cpu_rvalid <= 1'b0;
          cpu_hit    <= 1'b0;
          cpu_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          cpu_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
